// File: rtl/sdram_burst_responder.sv
// rtl/sdram_burst_responder.sv - responder side of the SDRAM burst req/ack handshake
// Grants write/read bursts, streams words to a fixed-latency memory port, enforces an idle gap.
module sdram_burst_responder #(
  parameter int AW       = 24,
  parameter int DW       = 16,
  parameter int LW       = 10,
  parameter int RD_LAT   = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic          clk_ref,
  input  logic          rst,
  input  logic          sdram_init_done,
  input  logic          sdram_wr_req,
  input  logic [AW-1:0] sdram_wr_addr,
  input  logic [LW-1:0] wr_len,
  output logic          sdram_wr_ack,
  input  logic [DW-1:0] sdram_din,
  input  logic          sdram_rd_req,
  input  logic [AW-1:0] sdram_rd_addr,
  input  logic [LW-1:0] rd_len,
  output logic          sdram_rd_ack,
  output logic [DW-1:0] sdram_dout,
  input  logic          mem_busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int GW = $clog2(IDLE_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WR_LAST,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_GAP
  } state_t;

  state_t        state, state_n;
  logic [LW:0]   cnt, cnt_n;
  logic [LW-1:0] len_q, len_n;
  logic [AW-1:0] addr, addr_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          wr_ack_n, mem_en_n, mem_we_n;
  logic [AW-1:0] mem_addr_n;
  logic [RD_LAT-1:0] rd_pipe, rd_pipe_n, rd_lo;
  logic [DW-1:0] dout_hold;
  logic          last_beat;

  // rd_pipe tracks issued reads; its top bit is the registered rd_ack.
  assign sdram_rd_ack = rd_pipe[RD_LAT-1];
  assign rd_lo        = rd_pipe << 1;
  assign last_beat    = (cnt == {1'b0, len_q});

  assign sdram_dout = sdram_rd_ack ? mem_rdata : dout_hold;
  assign mem_wdata  = (mem_en && mem_we) ? sdram_din : '0;

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      len_q        <= '0;
      addr         <= '0;
      gap_cnt      <= '0;
      sdram_wr_ack <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      rd_pipe      <= '0;
      dout_hold    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      len_q        <= len_n;
      addr         <= addr_n;
      gap_cnt      <= gap_n;
      sdram_wr_ack <= wr_ack_n;
      mem_en       <= mem_en_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      rd_pipe      <= rd_pipe_n;
      if (sdram_rd_ack) begin
        dout_hold <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    len_n      = len_q;
    addr_n     = addr;
    gap_n      = gap_cnt;
    wr_ack_n   = 1'b0;
    mem_en_n   = 1'b0;
    mem_we_n   = 1'b0;
    mem_addr_n = mem_addr;
    rd_pipe_n    = rd_pipe << 1;
    rd_pipe_n[0] = mem_en && !mem_we;

    case (state)
      S_IDLE: begin
        // Zero-length requests are never granted, so they cannot block the other direction.
        if (sdram_init_done && !mem_busy && gap_cnt == '0) begin
          if (sdram_wr_req && wr_len != '0) begin
            state_n  = S_WRITE;
            wr_ack_n = 1'b1;
            cnt_n    = (LW+1)'(1);
            len_n    = wr_len;
            addr_n   = sdram_wr_addr;
          end else if (sdram_rd_req && rd_len != '0) begin
            state_n    = S_RD_ISSUE;
            mem_en_n   = 1'b1;
            mem_addr_n = sdram_rd_addr;
            addr_n     = sdram_rd_addr + AW'(1);
            cnt_n      = (LW+1)'(1);
            len_n      = rd_len;
          end
        end
      end

      S_WRITE: begin
        // Write data trails each ack by one cycle, so the memory beat lags the ack.
        mem_en_n   = 1'b1;
        mem_we_n   = 1'b1;
        mem_addr_n = addr;
        addr_n     = addr + AW'(1);
        if (last_beat) begin
          state_n = S_WR_LAST;
        end else begin
          wr_ack_n = 1'b1;
          cnt_n    = cnt + (LW+1)'(1);
        end
      end

      S_WR_LAST: begin
        state_n = S_GAP;
        gap_n   = GW'(IDLE_GAP - 1);
      end

      S_RD_ISSUE: begin
        if (last_beat) begin
          state_n = S_RD_DRAIN;
        end else begin
          mem_en_n   = 1'b1;
          mem_addr_n = addr;
          addr_n     = addr + AW'(1);
          cnt_n      = cnt + (LW+1)'(1);
        end
      end

      S_RD_DRAIN: begin
        // Leave once the current rd_ack cycle is the final one in flight.
        if (rd_lo == '0) begin
          state_n = S_GAP;
          gap_n   = GW'(IDLE_GAP - 1);
        end
      end

      S_GAP: begin
        if (gap_cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// tb/tb_sdram_burst_responder.sv - directed vector and sequence bench for sdram_burst_responder
module tb_sdram_burst_responder;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        sdram_init_done;
  logic        sdram_wr_req;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  wr_len;
  logic        sdram_wr_ack;
  logic [15:0] sdram_din;
  logic        sdram_rd_req;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  rd_len;
  logic        sdram_rd_ack;
  logic [15:0] sdram_dout;
  logic        mem_busy;
  logic        mem_en;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_burst_responder #(
    .AW(24), .DW(16), .LW(10), .RD_LAT(2), .IDLE_GAP(4)
  ) dut (
    .clk_ref        (clk_ref),
    .rst            (rst),
    .sdram_init_done(sdram_init_done),
    .sdram_wr_req   (sdram_wr_req),
    .sdram_wr_addr  (sdram_wr_addr),
    .wr_len         (wr_len),
    .sdram_wr_ack   (sdram_wr_ack),
    .sdram_din      (sdram_din),
    .sdram_rd_req   (sdram_rd_req),
    .sdram_rd_addr  (sdram_rd_addr),
    .rd_len         (rd_len),
    .sdram_rd_ack   (sdram_rd_ack),
    .sdram_dout     (sdram_dout),
    .mem_busy       (mem_busy),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk_ref = ~clk_ref;

  // Read memory model: data for a read strobe appears two cycles later.
  logic [15:0] mem [logic [23:0]];
  logic [15:0] rp0 = '0, rp1 = '0;

  function automatic logic [15:0] mem_read(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 16'hDEAD;
  endfunction

  always @(posedge clk_ref) begin
    rp0 <= (mem_en && !mem_we) ? mem_read(mem_addr) : 16'h0000;
    rp1 <= rp0;
  end
  assign mem_rdata = rp1;

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    sdram_init_done = 1'b1;
    mem_busy        = 1'b0;
    sdram_wr_req    = 1'b0;
    sdram_rd_req    = 1'b0;
    sdram_wr_addr   = '0;
    sdram_rd_addr   = '0;
    wr_len          = '0;
    rd_len          = '0;
    sdram_din       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_burst(input string nm, input logic [23:0] base, input int len);
    logic [23:0] a;
    sdram_wr_req  = 1'b1;
    sdram_wr_addr = base;
    wr_len        = 10'(len);
    for (int k = 1; k <= len + 6; k++) begin
      tick();
      if (k == 1) begin
        sdram_wr_req  = 1'b0;
        sdram_wr_addr = 24'hABCDEF;
        wr_len        = 10'd7;
      end
      sdram_din = (k >= 2 && k <= len + 1) ? 16'(16'hA0 + k - 2) : 16'h5555;
      #1;
      check({nm, "_wr_ack"}, sdram_wr_ack, (k >= 1 && k <= len));
      check({nm, "_mem_en"}, mem_en, (k >= 2 && k <= len + 1));
      if (k >= 2 && k <= len + 1) begin
        a = base + 24'(k - 2);
        check({nm, "_mem_we"}, mem_we, 1);
        check({nm, "_mem_addr"}, mem_addr, a);
        check({nm, "_wdata"}, mem_wdata, 16'hA0 + k - 2);
      end
    end
  endtask

  task automatic read_burst(input string nm, input logic [23:0] base, input int len,
                            input logic [15:0] d0, input int busy_k);
    logic [23:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 24'(i);
      mem[a] = d0 + 16'(i);
    end
    sdram_rd_req  = 1'b1;
    sdram_rd_addr = base;
    rd_len        = 10'(len);
    for (int k = 1; k <= len + 6; k++) begin
      tick();
      if (k == 1) begin
        sdram_rd_req  = 1'b0;
        sdram_rd_addr = 24'h123456;
        rd_len        = 10'd1;
      end
      if (k == busy_k) mem_busy = 1'b1;
      #1;
      check({nm, "_mem_en"}, mem_en, (k <= len));
      if (k <= len) begin
        a = base + 24'(k - 1);
        check({nm, "_mem_we"}, mem_we, 0);
        check({nm, "_mem_addr"}, mem_addr, a);
      end
      check({nm, "_rd_ack"}, sdram_rd_ack, (k >= 3 && k <= len + 2));
      if (k >= 3 && k <= len + 2) check({nm, "_dout"}, sdram_dout, d0 + 16'(k - 3));
      if (k == len + 5) check({nm, "_dout_hold"}, sdram_dout, d0 + 16'(len - 1));
    end
    mem_busy = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic       init;
    logic       busy;
    logic [9:0] wlen;
    logic [9:0] rlen;
    int         exp;   // 0 none, 1 write grant, 2 read grant
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd1, 10'd0, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd1, 2};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd2, 10'd2, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd1, 10'd0, 0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd1, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd3, 2};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd4, 10'd4, 0};

    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_wr_ack", sdram_wr_ack, 0);
    check("rst_rd_ack", sdram_rd_ack, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dout", sdram_dout, 0);
    check("rst_wdata", mem_wdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // Grant-condition vectors, each from a fresh reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      sdram_wr_req    = vecs[i].wr;
      sdram_rd_req    = vecs[i].rd;
      sdram_init_done = vecs[i].init;
      mem_busy        = vecs[i].busy;
      wr_len          = vecs[i].wlen;
      rd_len          = vecs[i].rlen;
      sdram_wr_addr   = 24'h000010;
      sdram_rd_addr   = 24'h000020;
      tick();
      check($sformatf("vec%0d_wr_ack", i), sdram_wr_ack, (vecs[i].exp == 1));
      check($sformatf("vec%0d_mem_en", i), mem_en, (vecs[i].exp == 2));
      check($sformatf("vec%0d_mem_we", i), mem_we, 0);
      idle_inputs();
    end

    // T1 write burst
    do_reset();
    write_burst("t1", 24'h000100, 4);

    // T2 read burst
    do_reset();
    read_burst("t2", 24'h000200, 4, 16'h00B0, 0);

    // T4 address wrap
    do_reset();
    read_burst("t4", 24'hFFFFFE, 4, 16'h00C0, 0);

    // T5b mem_busy raised mid-burst
    do_reset();
    read_burst("t5b", 24'h000300, 4, 16'h00E0, 2);

    // T3 simultaneous requests: write first, gap, then read
    do_reset();
    mem[24'h000600] = 16'h0D00;
    mem[24'h000601] = 16'h0D01;
    sdram_wr_req  = 1'b1; sdram_wr_addr = 24'h000500; wr_len = 10'd2;
    sdram_rd_req  = 1'b1; sdram_rd_addr = 24'h000600; rd_len = 10'd2;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) sdram_wr_req = 1'b0;
      if (k == 9) sdram_rd_req = 1'b0;
      #1;
      check("t3_wr_ack", sdram_wr_ack, (k >= 1 && k <= 2));
      check("t3_wr_en", mem_en && mem_we, (k >= 2 && k <= 3));
      check("t3_rd_en", mem_en && !mem_we, (k >= 9 && k <= 10));
      check("t3_rd_ack", sdram_rd_ack, (k >= 11 && k <= 12));
      if (k == 9)  check("t3_rd_addr0", mem_addr, 24'h000600);
      if (k == 12) check("t3_dout1", sdram_dout, 16'h0D01);
    end
    idle_inputs();

    // T5 init_done / mem_busy hold off the grant
    do_reset();
    sdram_init_done = 1'b0;
    sdram_wr_req = 1'b1; sdram_wr_addr = 24'h000700; wr_len = 10'd2;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) begin sdram_init_done = 1'b1; mem_busy = 1'b1; end
      if (k == 5) mem_busy = 1'b0;
      check("t5_wr_ack", sdram_wr_ack, (k == 6));
      check("t5_mem_en", mem_en, 0);
    end
    idle_inputs();

    // T6 reset in the middle of an L=8 write, then zero-length requests
    do_reset();
    sdram_wr_req = 1'b1; sdram_wr_addr = 24'h000400; wr_len = 10'd8;
    tick();
    sdram_wr_req = 1'b0;
    check("t6_ack_b0", sdram_wr_ack, 1);
    tick();
    check("t6_en_b1", mem_en, 1);
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_ack", sdram_wr_ack, 0);
    check("t6_rst_en", mem_en, 0);
    check("t6_rst_we", mem_we, 0);
    tick();
    rst = 1'b0;
    sdram_wr_req = 1'b1; wr_len = 10'd0;
    sdram_rd_req = 1'b1; rd_len = 10'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t6_len0_wr_ack", sdram_wr_ack, 0);
      check("t6_len0_rd_ack", sdram_rd_ack, 0);
      check("t6_len0_mem_en", mem_en, 0);
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
